// File: rtl/fpu_ss_mem_bridge.sv
// fpu_ss_mem_bridge: FPU subsystem memory request/response bridge onto an OBI
// data port. Word accesses only by default; defining FPU_SS_MEM_BRIDGE_HALF_EN
// additionally allows halfword (funct3 3'b001) accesses with NaN-boxed loads.
//
// cmem_q/cmem_p handshakes: a transfer happens on a rising clk_i edge where
// valid and ready are both 1; once valid is raised its payload is held until
// that edge. The OBI address phase follows the same rule with data_req_o/data_gnt_i.
// data_rvalid_i cannot be stalled.

package acc_pkg;
    localparam int AddrWidth = 32;
    typedef enum logic { READ = 1'b0, WRITE = 1'b1 } mem_req_type_e;
endpackage

module fpu_ss_mem_bridge #(
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           cmem_q_valid_i,
    output logic                           cmem_q_ready_o,
    input  logic [31:0]                    cmem_q_laddr_i,
    input  logic [31:0]                    cmem_q_wdata_i,
    input  logic [2:0]                     cmem_q_width_i,
    input  acc_pkg::mem_req_type_e         cmem_q_req_type_i,
    input  logic [31:0]                    cmem_q_hart_id_i,
    input  logic [acc_pkg::AddrWidth-1:0]  cmem_q_addr_i,
    output logic                           cmem_p_valid_o,
    input  logic                           cmem_p_ready_i,
    output logic [31:0]                    cmem_p_rdata_o,
    output logic                           cmem_p_status_o,
    output logic [31:0]                    cmem_p_hart_id_o,
    output logic [acc_pkg::AddrWidth-1:0]  cmem_p_addr_o,
    output logic                           data_req_o,
    input  logic                           data_gnt_i,
    output logic [31:0]                    data_addr_o,
    output logic                           data_we_o,
    output logic [3:0]                     data_be_o,
    output logic [31:0]                    data_wdata_o,
    input  logic                           data_rvalid_i,
    input  logic [31:0]                    data_rdata_i,
    input  logic                           data_err_i,
    output logic                           dbg_state_o
);

    localparam int AW = acc_pkg::AddrWidth;
    localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic { S_IDLE = 1'b0, S_REQ = 1'b1 } state_e;

    state_e state_q, state_d;

    // Tracking FIFO: one entry per granted bus access awaiting rvalid.
    logic          trk_we_q   [MAX_OUTSTANDING];
    logic          trk_half_q [MAX_OUTSTANDING];
    logic          trk_hi_q   [MAX_OUTSTANDING];
    logic [31:0]   trk_hart_q [MAX_OUTSTANDING];
    logic [AW-1:0] trk_addr_q [MAX_OUTSTANDING];
    logic [PW-1:0] trk_wr_q, trk_rd_q;
    logic [CW-1:0] trk_cnt_q;

    // Response FIFO: registered head, so a push is visible one cycle later.
    logic [31:0]   rsp_rdata_q  [MAX_OUTSTANDING];
    logic          rsp_status_q [MAX_OUTSTANDING];
    logic [31:0]   rsp_hart_q   [MAX_OUTSTANDING];
    logic [AW-1:0] rsp_addr_q   [MAX_OUTSTANDING];
    logic [PW-1:0] rsp_wr_q, rsp_rd_q;
    logic [CW-1:0] rsp_cnt_q;

    // Captured request (address phase payload plus echo fields).
    logic          req_we_q, req_half_q, req_hi_q;
    logic [31:0]   req_addr_q, req_wdata_q, req_hart_q;
    logic [3:0]    req_be_q;
    logic [AW-1:0] req_acc_addr_q;

    logic full_ok, half_ok, legal, credit_ok;
    logic q_fire, gnt_fire, rv_fire, ill_push, rsp_push, rsp_pop;
    logic [31:0]   push_rdata, push_hart;
    logic          push_status;
    logic [AW-1:0] push_addr;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (int'(p) == MAX_OUTSTANDING - 1) ? '0 : p + 1'b1;
    endfunction

    // Request legality and credit check.
    always_comb begin
        full_ok = (cmem_q_width_i == 3'b010) && (cmem_q_laddr_i[1:0] == 2'b00);
`ifdef FPU_SS_MEM_BRIDGE_HALF_EN
        half_ok = (cmem_q_width_i == 3'b001) && !cmem_q_laddr_i[0];
`else
        half_ok = 1'b0;
`endif
        legal     = full_ok || half_ok;
        credit_ok = (int'(trk_cnt_q) + int'(rsp_cnt_q)) < MAX_OUTSTANDING;
    end

    assign q_fire   = cmem_q_valid_i && cmem_q_ready_o;
    assign gnt_fire = (state_q == S_REQ) && data_gnt_i;
    assign rv_fire  = data_rvalid_i && (trk_cnt_q != '0);
    assign ill_push = q_fire && !legal;
    assign rsp_push = rv_fire || ill_push;
    assign rsp_pop  = cmem_p_valid_o && cmem_p_ready_i;

    // FSM state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // FSM next state: legal request opens an address phase, grant closes it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (q_fire && legal) state_d = S_REQ;
            S_REQ:   if (data_gnt_i)      state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs; illegal requests wait until no bus access is outstanding so responses stay ordered.
    always_comb begin
        cmem_q_ready_o = !rst_i && (state_q == S_IDLE) && credit_ok && (legal || (trk_cnt_q == '0));
        data_req_o     = (state_q == S_REQ);
        dbg_state_o    = state_q;
    end

    // Capture the address-phase payload on a legal request handshake.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            req_we_q       <= 1'b0;
            req_half_q     <= 1'b0;
            req_hi_q       <= 1'b0;
            req_addr_q     <= '0;
            req_wdata_q    <= '0;
            req_hart_q     <= '0;
            req_be_q       <= '0;
            req_acc_addr_q <= '0;
        end else if (q_fire && legal) begin
            req_we_q       <= (cmem_q_req_type_i == acc_pkg::WRITE);
            req_half_q     <= half_ok;
            req_hi_q       <= cmem_q_laddr_i[1];
            req_addr_q     <= {cmem_q_laddr_i[31:2], 2'b00};
            req_wdata_q    <= half_ok ? {2{cmem_q_wdata_i[15:0]}} : cmem_q_wdata_i;
            req_hart_q     <= cmem_q_hart_id_i;
            req_be_q       <= half_ok ? (cmem_q_laddr_i[1] ? 4'b1100 : 4'b0011) : 4'b1111;
            req_acc_addr_q <= cmem_q_addr_i;
        end
    end

    assign data_addr_o  = req_addr_q;
    assign data_we_o    = req_we_q;
    assign data_be_o    = req_be_q;
    assign data_wdata_o = req_wdata_q;

    // Tracking FIFO: push on grant, pop on rvalid (rvalid with nothing tracked is dropped).
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                trk_we_q[i]   <= 1'b0;
                trk_half_q[i] <= 1'b0;
                trk_hi_q[i]   <= 1'b0;
                trk_hart_q[i] <= '0;
                trk_addr_q[i] <= '0;
            end
            trk_wr_q  <= '0;
            trk_rd_q  <= '0;
            trk_cnt_q <= '0;
        end else begin
            if (gnt_fire) begin
                trk_we_q[trk_wr_q]   <= req_we_q;
                trk_half_q[trk_wr_q] <= req_half_q;
                trk_hi_q[trk_wr_q]   <= req_hi_q;
                trk_hart_q[trk_wr_q] <= req_hart_q;
                trk_addr_q[trk_wr_q] <= req_acc_addr_q;
                trk_wr_q             <= ptr_inc(trk_wr_q);
            end
            if (rv_fire) trk_rd_q <= ptr_inc(trk_rd_q);
            case ({gnt_fire, rv_fire})
                2'b10:   trk_cnt_q <= trk_cnt_q + CW'(1);
                2'b01:   trk_cnt_q <= trk_cnt_q - CW'(1);
                default: trk_cnt_q <= trk_cnt_q;
            endcase
        end
    end

    // Response payload: bus completion has priority (the two never coincide by construction).
    always_comb begin
        push_rdata  = '0;
        push_status = 1'b1;
        push_hart   = cmem_q_hart_id_i;
        push_addr   = cmem_q_addr_i;
        if (rv_fire) begin
            if (!trk_we_q[trk_rd_q]) begin
                if (trk_half_q[trk_rd_q])
                    push_rdata = {16'hFFFF, trk_hi_q[trk_rd_q] ? data_rdata_i[31:16] : data_rdata_i[15:0]};
                else
                    push_rdata = data_rdata_i;
            end
            push_status = data_err_i;
            push_hart   = trk_hart_q[trk_rd_q];
            push_addr   = trk_addr_q[trk_rd_q];
        end
    end

    // Response FIFO storage and occupancy.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                rsp_rdata_q[i]  <= '0;
                rsp_status_q[i] <= 1'b0;
                rsp_hart_q[i]   <= '0;
                rsp_addr_q[i]   <= '0;
            end
            rsp_wr_q  <= '0;
            rsp_rd_q  <= '0;
            rsp_cnt_q <= '0;
        end else begin
            if (rsp_push) begin
                rsp_rdata_q[rsp_wr_q]  <= push_rdata;
                rsp_status_q[rsp_wr_q] <= push_status;
                rsp_hart_q[rsp_wr_q]   <= push_hart;
                rsp_addr_q[rsp_wr_q]   <= push_addr;
                rsp_wr_q               <= ptr_inc(rsp_wr_q);
            end
            if (rsp_pop) rsp_rd_q <= ptr_inc(rsp_rd_q);
            case ({rsp_push, rsp_pop})
                2'b10:   rsp_cnt_q <= rsp_cnt_q + CW'(1);
                2'b01:   rsp_cnt_q <= rsp_cnt_q - CW'(1);
                default: rsp_cnt_q <= rsp_cnt_q;
            endcase
        end
    end

    assign cmem_p_valid_o   = (rsp_cnt_q != '0);
    assign cmem_p_rdata_o   = rsp_rdata_q[rsp_rd_q];
    assign cmem_p_status_o  = rsp_status_q[rsp_rd_q];
    assign cmem_p_hart_id_o = rsp_hart_q[rsp_rd_q];
    assign cmem_p_addr_o    = rsp_addr_q[rsp_rd_q];

endmodule
